// File: rtl/game_tick_gen_if.sv
// Signal bundle between the game tick generator and its neighbours: raw tick-source
// inputs from the board/VGA side and the tick strobes consumed by game logic.
interface game_tick_gen_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       mode_in;
    logic             frame_sync_in;
    logic             key_step_in;
    logic             clk_25Mhz_out;
    logic             pix_en_out;
    logic             tick_out;
    logic             slow_tick_out;
    logic [CNT_W-1:0] tick_count_out;

    modport master (
        output mode_in,
        output frame_sync_in,
        output key_step_in,
        input  clk_25Mhz_out,
        input  pix_en_out,
        input  tick_out,
        input  slow_tick_out,
        input  tick_count_out
    );

    modport slave (
        input  mode_in,
        input  frame_sync_in,
        input  key_step_in,
        output clk_25Mhz_out,
        output pix_en_out,
        output tick_out,
        output slow_tick_out,
        output tick_count_out
    );
endinterface

// File: rtl/game_tick_gen.sv
// Game tick generator: pixel clock/enable, a game-tick strobe from a run-time selected
// source (frame sync, rate divider, debounced key, pause), a slow strobe and a tick counter.
module game_tick_gen #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 60,
    parameter int PIX_DIV         = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SLOW_DIV        = 4,
    parameter int CNT_W           = 16
) (
    input  logic           clk_50Mhz_in,
    input  logic           reset_in,
    game_tick_gen_if.slave bus
);

    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PIX_W  = $clog2(PIX_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SLOW_W = $clog2(SLOW_DIV + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
    localparam logic [PIX_W-1:0]  PIX_HALF  = PIX_W'(PIX_DIV / 2 - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

    typedef enum logic [1:0] {
        MODE_FRAME = 2'd0,
        MODE_DIV   = 2'd1,
        MODE_KEY   = 2'd2,
        MODE_PAUSE = 2'd3
    } mode_e;

    logic [1:0]        mode_meta_q;
    mode_e             mode_sync_q;
    logic              frame_meta_q, frame_sync_q;
    logic              key_meta_q, key_sync_q;

    mode_e             mode_prev_q, mode_prev_d;
    logic              frame_prev_q, frame_prev_d;
    logic              key_acc_q, key_acc_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              pix_clk_q, pix_clk_d;
    logic              pix_en_q, pix_en_d;
    logic              tick_q, tick_d;
    logic              slow_tick_q, slow_tick_d;
    logic [SLOW_W-1:0] slow_cnt_q, slow_cnt_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;

    logic              mode_change;
    logic              frame_rise;
    logic              div_wrap;
    logic              key_press;
    logic              src_event;

    // Reset values park the mode in pause and the key as released so nothing ticks spuriously.
    always_ff @(posedge clk_50Mhz_in or negedge reset_in) begin
        if (!reset_in) begin
            mode_meta_q  <= 2'd3;
            mode_sync_q  <= MODE_PAUSE;
            frame_meta_q <= 1'b0;
            frame_sync_q <= 1'b0;
            key_meta_q   <= 1'b1;
            key_sync_q   <= 1'b1;
        end else begin
            mode_meta_q  <= bus.mode_in;
            mode_sync_q  <= mode_e'(mode_meta_q);
            frame_meta_q <= bus.frame_sync_in;
            frame_sync_q <= frame_meta_q;
            key_meta_q   <= bus.key_step_in;
            key_sync_q   <= key_meta_q;
        end
    end

    always_ff @(posedge clk_50Mhz_in or negedge reset_in) begin
        if (!reset_in) begin
            mode_prev_q  <= MODE_PAUSE;
            frame_prev_q <= 1'b0;
            key_acc_q    <= 1'b1;
            deb_q        <= '0;
            div_q        <= '0;
            pix_q        <= '0;
            pix_clk_q    <= 1'b0;
            pix_en_q     <= 1'b0;
            tick_q       <= 1'b0;
            slow_tick_q  <= 1'b0;
            slow_cnt_q   <= '0;
            tick_cnt_q   <= '0;
        end else begin
            mode_prev_q  <= mode_prev_d;
            frame_prev_q <= frame_prev_d;
            key_acc_q    <= key_acc_d;
            deb_q        <= deb_d;
            div_q        <= div_d;
            pix_q        <= pix_d;
            pix_clk_q    <= pix_clk_d;
            pix_en_q     <= pix_en_d;
            tick_q       <= tick_d;
            slow_tick_q  <= slow_tick_d;
            slow_cnt_q   <= slow_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
        end
    end

    always_comb begin
        mode_prev_d  = mode_sync_q;
        frame_prev_d = frame_sync_q;
        mode_change  = (mode_sync_q != mode_prev_q);
        frame_rise   = frame_sync_q & ~frame_prev_q;

        pix_d     = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
        pix_clk_d = pix_clk_q ^ ((pix_q == PIX_HALF) || (pix_q == PIX_LAST));
        pix_en_d  = (pix_d == PIX_LAST);

        // The debouncer runs in every mode; only the press edge is ever turned into a tick.
        key_acc_d = key_acc_q;
        deb_d     = '0;
        key_press = 1'b0;
        if (key_sync_q != key_acc_q) begin
            if (deb_q == DEB_LAST) begin
                key_acc_d = ~key_acc_q;
                key_press = key_acc_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end

        // Held at zero outside divider mode so the first tick lands DIV cycles after entry.
        div_d    = '0;
        div_wrap = 1'b0;
        if (mode_sync_q == MODE_DIV) begin
            if (div_q == DIV_LAST) begin
                div_wrap = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        src_event = 1'b0;
        case (mode_sync_q)
            MODE_FRAME: src_event = frame_rise;
            MODE_DIV:   src_event = div_wrap;
            MODE_KEY:   src_event = key_press;
            default:    src_event = 1'b0;
        endcase

        tick_d = src_event & ~mode_change & ~tick_q;

        slow_cnt_d  = slow_cnt_q;
        slow_tick_d = 1'b0;
        tick_cnt_d  = tick_cnt_q;
        if (tick_d) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (slow_cnt_q == SLOW_LAST) begin
                slow_cnt_d  = '0;
                slow_tick_d = 1'b1;
            end else begin
                slow_cnt_d = slow_cnt_q + 1'b1;
            end
        end
    end

    assign bus.clk_25Mhz_out  = pix_clk_q;
    assign bus.pix_en_out     = pix_en_q;
    assign bus.tick_out       = tick_q;
    assign bus.slow_tick_out  = slow_tick_q;
    assign bus.tick_count_out = tick_cnt_q;

endmodule
